// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined core's load/store port.
// It accepts one request, waits a configurable number of cycles, then returns a one-cycle response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int unsigned IDXW  = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 32'd1;
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 32'd4);
  localparam logic [3:0]  WLAST = 4'(WAIT_STATES - 32'd1);

  state_t      state_r, state_nx_s;
  logic [3:0]  cnt_r, cnt_nx_s;
  logic        we_r, uns_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r, wdata_r;
  logic        req_ready_r, rsp_valid_r, rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_valid_nx_s, rsp_err_nx_s;
  logic [31:0] rsp_rdata_nx_s;
  logic [31:0] off_s, rd_word_s;
  logic [IDXW-1:0] idx_s;
  logic        misal_s, err_s, wr_s;
  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      2'b10:   r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  // Fault check and word index for the captured request; offsets below base wrap high and fault.
  always_comb begin
    off_s = addr_r - BASE_ADDR;
    case (size_r)
      2'b00:   misal_s = 1'b0;
      2'b01:   misal_s = addr_r[0];
      2'b10:   misal_s = (addr_r[1:0] != 2'b00);
      default: misal_s = 1'b1;
    endcase
    err_s     = misal_s | (off_s >= SPAN);
    idx_s     = off_s[IDXW+1:2];
    rd_word_s = mem[idx_s];
    wr_s      = (state_r == ST_ACCESS) & we_r & ~err_s & reset;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_nx_s = (WAIT_STATES > 32'd0) ? ST_WAIT : ST_ACCESS;
          cnt_nx_s   = 4'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == WLAST) begin
          state_nx_s = ST_ACCESS;
          cnt_nx_s   = 4'd0;
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      ST_ACCESS: state_nx_s = ST_RESP;
      ST_RESP:   state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // Response values to register; only the access edge produces a non-zero response.
  always_comb begin
    rsp_valid_nx_s = 1'b0;
    rsp_err_nx_s   = 1'b0;
    rsp_rdata_nx_s = 32'h0000_0000;
    if (state_r == ST_ACCESS) begin
      rsp_valid_nx_s = 1'b1;
      rsp_err_nx_s   = err_s;
      if (err_s || we_r) rsp_rdata_nx_s = 32'h0000_0000;
      else               rsp_rdata_nx_s = load_extract(rd_word_s, addr_r[1:0], size_r, uns_r);
    end else begin
      rsp_valid_nx_s = 1'b0;
    end
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      size_r      <= 2'b00;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      req_ready_r <= (state_nx_s == ST_IDLE);
      rsp_valid_r <= rsp_valid_nx_s;
      rsp_err_r   <= rsp_err_nx_s;
      rsp_rdata_r <= rsp_rdata_nx_s;
      if (state_r == ST_IDLE && req_valid) begin
        we_r    <= req_we;
        uns_r   <= req_unsigned;
        size_r  <= req_size;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_s) mem[idx_s] <= store_merge(rd_word_s, wdata_r, addr_r[1:0], size_r);
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with 1 wait state and one with 3,
// checked against a byte-level memory model.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0]       req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_err;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;

  logic [31:0] model [2][DEPTH];
  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {err, rdata}; applies successful stores to the model.
  function automatic logic [32:0] ref_access(input int d, input bit we, input logic [1:0] size,
                                             input bit uns, input logic [31:0] addr,
                                             input logic [31:0] wdata);
    longint unsigned off, mask, word, v, wd;
    int nbytes, lane, idx;
    bit err;
    off = {32'd0, addr};
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0)
          || (off >= 64'(DEPTH * 4));
    if (err) return {1'b1, 32'h0};
    nbytes = 1 << size;
    lane   = int'(addr[1:0]);
    idx    = int'(off / 64'd4);
    mask   = ((64'd1 << (8 * nbytes)) - 64'd1) << (8 * lane);
    word   = {32'd0, model[d][idx]};
    if (we) begin
      wd = {32'd0, wdata};
      model[d][idx] = 32'((word & ~mask) | ((wd << (8 * lane)) & mask));
      return {1'b0, 32'h0};
    end
    v = (word & mask) >> (8 * lane);
    if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~((64'd1 << (8 * nbytes)) - 64'd1);
    return {1'b0, v[31:0]};
  endfunction

  // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle again.
  task automatic xact(input int d, input bit hold, input bit we, input logic [1:0] size,
                      input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] got);
    logic [32:0] e;
    int ws;
    ws  = (d == 0) ? 1 : 3;
    e   = ref_access(d, we, size, uns, addr, wdata);
    got = 32'h0;
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wdata;
    check("ready_before_accept", {31'd0, req_ready[d]}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= ws + 3; k++) begin
      @(negedge clk);
      check($sformatf("rsp_valid_k%0d", k), {31'd0, rsp_valid[d]}, (k == ws + 2) ? 32'd1 : 32'd0);
      check($sformatf("req_ready_k%0d", k), {31'd0, req_ready[d]}, (k == ws + 3) ? 32'd1 : 32'd0);
      if (k == ws + 2) begin
        check($sformatf("rdata_%h", addr), rsp_rdata[d], e[31:0]);
        check($sformatf("err_%h", addr), {31'd0, rsp_err[d]}, {31'd0, e[32]});
        got = rsp_rdata[d];
      end
      if (k == 1) begin
        req_valid[d] = hold; req_we[d] = 1'($urandom); req_size[d] = 2'($urandom);
        req_unsigned[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom;
      end
    end
  endtask

  initial begin
    logic [31:0] got, prior;
    logic [31:0] a;
    req_valid = '0; req_we = '0; req_unsigned = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", {31'd0, req_ready[d]}, 32'd1);
      check("reset_valid", {31'd0, rsp_valid[d]}, 32'd0);
      check("reset_rdata", rsp_rdata[d], 32'd0);
      check("reset_err", {31'd0, rsp_err[d]}, 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // Give every word known contents.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++) xact(d, 1'b0, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, got);

    // Directed sequence on the 1-wait-state instance.
    xact(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);  check("lw_deadbeef", got, 32'hDEADBEEF);
    xact(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, got);
    xact(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h80, got);
    xact(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, got);  check("lb_13", got, 32'hFFFFFF80);
    xact(0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, got);  check("lbu_13", got, 32'h00000080);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got);  check("lw_10", got, 32'h80000000);
    xact(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, got);
    xact(0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, got);  check("lh_22", got, 32'h00001234);
    xact(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h8001, got);
    xact(0, 1'b0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, got);  check("lhu_20", got, 32'h00008001);
    xact(0, 1'b0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, got);  check("lh_20", got, 32'hFFFF8001);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, got);  check("lw_20", got, 32'h1234_8001);

    // Faulting accesses, then confirm neighbouring words are untouched.
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, got);
    xact(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, got);
    xact(0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h04, 32'hFFFFFFFF, got);
    xact(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'(DEPTH * 4), 32'hFFFFFFFF, got);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, got);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, got);  check("lw_00_after_fault", got, model[0][0]);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, got);  check("lw_04_after_fault", got, model[0][1]);
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, got);

    // Three back-to-back requests with req_valid held high on the 3-wait-state instance.
    xact(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, got);
    xact(1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h41, 32'h000000A5, got);
    xact(1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, got);  check("b2b_lw_40", got, 32'hCAFEA50D);

    // Reset while a store is waiting: no response, no write.
    prior = model[0][12];
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'b10; req_unsigned[0] = 1'b0;
    req_addr[0] = 32'h30; req_wdata[0] = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_ready", {31'd0, req_ready[0]}, 32'd1);
    check("midrst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("midrst_rdata", rsp_rdata[0], 32'd0);
    check("midrst_err", {31'd0, rsp_err[0]}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    end
    xact(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, got);  check("lw_30_prior", got, prior);

    // Randomized traffic against the model, occasionally with req_valid held high.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
        xact(d, (i != 59) && ($urandom_range(0, 1) == 1), 1'($urandom), 2'($urandom),
             1'($urandom), a, $urandom, got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
